mem_1r1w_fifo_ctrl: RTL and testbench

//  Single-clock FIFO sequencer for mem_1r1w_sync_fpga (both memory clocks tied to clk_i). Owns write/read

---
 rtl/mem_1r1w_fifo_ctrl_pkg.sv | 17 +
 rtl/mem_1r1w_fifo_pipe_track.sv | 48 ++++
 rtl/mem_1r1w_fifo_ctrl.sv | 101 ++++++++++
 tb/tb_mem_1r1w_fifo_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_1r1w_fifo_ctrl_pkg.sv
// mem_1r1w_fifo_ctrl_pkg: shared constants and pointer helper
// for the 1R1W RAM FIFO sequencer and its bench.
package mem_1r1w_fifo_ctrl_pkg;

  localparam int unsigned ELS_MIN  = 2;
  localparam int unsigned PIPE_MIN = 1;

  // Occupancy of a wrap-bit pointer pair, modulo 2^pw.
  function automatic int unsigned ptr_diff(
    input int unsigned wr,
    input int unsigned rd,
    input int unsigned pw
  );
    return (wr - rd) & ((32'd1 << pw) - 32'd1);
  endfunction

endpackage

// File: rtl/mem_1r1w_fifo_pipe_track.sv
// mem_1r1w_fifo_pipe_track: P-bit valid shifter mirroring
// a RAM output pipeline; bubbles collapse while head stalls.
module mem_1r1w_fifo_pipe_track
  import mem_1r1w_fifo_ctrl_pkg::*;
#(
  parameter int unsigned P = 2
) (
  input  logic         clk_i,
  input  logic         reset_n_i,
  input  logic         clear_i,
  input  logic         load_i,
  input  logic         yumi_i,
  output logic [P-1:0] valid_o,
  output logic         adv_out0_o
);

  localparam int unsigned A1 = (P > 1) ? 1 : 0;

  if (P < PIPE_MIN) begin : g_bad_p
    $error("pipe_track: P below minimum");
  end

  logic [P-1:0] valid_q, valid_d;
  logic         yumi_eff;

  // Advance rules and next valid vector.
  always_comb begin
    // A yumi with an empty head is ignored.
    yumi_eff   = yumi_i & valid_q[P-1];
    adv_out0_o = (P > 1) ? (yumi_eff | ~valid_q[A1]) : yumi_eff;
    valid_d    = valid_q;
    for (int j = 1; j < P; j++) begin
      if (yumi_eff | ~valid_q[j]) valid_d[j] = valid_q[j-1];
    end
    if (load_i)          valid_d[0] = 1'b1;
    else if (adv_out0_o) valid_d[0] = 1'b0;
    if (clear_i)         valid_d    = '0;
  end

  // Valid bit register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) valid_q <= '0;
    else            valid_q <= valid_d;
  end

  assign valid_o = valid_q;

endmodule

// File: rtl/mem_1r1w_fifo_ctrl.sv
// mem_1r1w_fifo_ctrl: single-clock FIFO sequencer for a 1R1W RAM.
// Optional MEM_1R1W_FIFO_CTRL_CLEAR_EN adds synchronous clear_i.
module mem_1r1w_fifo_ctrl
  import mem_1r1w_fifo_ctrl_pkg::*;
#(
  parameter int unsigned els_p             = 64,
  parameter int unsigned pipeline_output_p = 2,
  localparam int unsigned AW = $clog2(els_p),
  localparam int unsigned CW =
    $clog2(els_p + pipeline_output_p + 1)
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic                         enq_v_i,
  output logic                         enq_ready_o,
  output logic                         deq_v_o,
  input  logic                         deq_yumi_i,
`ifdef MEM_1R1W_FIFO_CTRL_CLEAR_EN
  input  logic                         clear_i,
`endif
  output logic                         mem_w_v_o,
  output logic [AW-1:0]                mem_w_addr_o,
  output logic                         mem_r_v_o,
  output logic [AW-1:0]                mem_r_addr_o,
  output logic                         mem_output_ready_o,
  output logic [pipeline_output_p-1:0] mem_valid_pipe_o,
  output logic [CW-1:0]                count_o
);

  localparam int unsigned P  = pipeline_output_p;
  localparam int unsigned PW = AW + 1;

  if (els_p < ELS_MIN || (1 << AW) != els_p) begin : g_bad_els
    $error("fifo_ctrl: els_p must be a power of 2 >= 2");
  end

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] mem_count;
  logic [P-1:0]  valid;
  logic          adv_out0;
  logic          clr;
  logic [CW-1:0] pipe_cnt;

`ifdef MEM_1R1W_FIFO_CTRL_CLEAR_EN
  assign clr = clear_i;
`else
  assign clr = 1'b0;
`endif

  mem_1r1w_fifo_pipe_track #(.P(P)) u_track (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .clear_i    (clr),
    .load_i     (mem_r_v_o),
    .yumi_i     (deq_yumi_i),
    .valid_o    (valid),
    .adv_out0_o (adv_out0)
  );

  // Handshakes, RAM strobes, next pointers and occupancy.
  always_comb begin
    mem_count = PW'(ptr_diff(32'(wr_ptr_q), 32'(rd_ptr_q), PW));
    // Ready depends only on flops, never on the deq side.
    enq_ready_o = (mem_count != PW'(els_p)) & ~clr;
    mem_w_v_o   = enq_v_i & enq_ready_o;
    mem_r_v_o   = (mem_count != '0) & (~valid[0] | adv_out0) & ~clr;
    wr_ptr_d    = wr_ptr_q + PW'(mem_w_v_o);
    rd_ptr_d    = rd_ptr_q + PW'(mem_r_v_o);
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
    pipe_cnt = '0;
    for (int j = 0; j < P; j++) pipe_cnt = pipe_cnt + CW'(valid[j]);
    count_o            = CW'(mem_count) + pipe_cnt;
    mem_w_addr_o       = wr_ptr_q[AW-1:0];
    mem_r_addr_o       = rd_ptr_q[AW-1:0];
    deq_v_o            = valid[P-1];
    mem_output_ready_o = deq_yumi_i;
    mem_valid_pipe_o   = valid;
  end

  // Pointer registers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Consumer may only take a word that is present.
  yumi_legal_a : assert property (
    @(posedge clk_i) disable iff (!reset_n_i)
    deq_yumi_i |-> deq_v_o
  );

endmodule

// File: tb/tb_mem_1r1w_fifo_ctrl.sv
// tb_mem_1r1w_fifo_ctrl: directed + random bench with queue model
// and a behavioural RAM beside the DUT.
module tb_mem_1r1w_fifo_ctrl;
  import mem_1r1w_fifo_ctrl_pkg::*;

  localparam int ELS = 4;
  localparam int P   = 2;
  localparam int AW  = 2;
  localparam int CW  = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          enq_v = 1'b0;
  logic          yumi = 1'b0;
  logic          enq_ready, deq_v, w_v, r_v, out_rdy;
  logic [AW-1:0] w_addr, r_addr;
  logic [P-1:0]  pipe;
  logic [CW-1:0] cnt;
`ifdef MEM_1R1W_FIFO_CTRL_CLEAR_EN
  logic          clear = 1'b0;
`endif

  always #5 clk = ~clk;

  mem_1r1w_fifo_ctrl #(.els_p(ELS), .pipeline_output_p(P)) dut (
    .clk_i              (clk),
    .reset_n_i          (rst_n),
    .enq_v_i            (enq_v),
    .enq_ready_o        (enq_ready),
    .deq_v_o            (deq_v),
    .deq_yumi_i         (yumi),
`ifdef MEM_1R1W_FIFO_CTRL_CLEAR_EN
    .clear_i            (clear),
`endif
    .mem_w_v_o          (w_v),
    .mem_w_addr_o       (w_addr),
    .mem_r_v_o          (r_v),
    .mem_r_addr_o       (r_addr),
    .mem_output_ready_o (out_rdy),
    .mem_valid_pipe_o   (pipe),
    .count_o            (cnt)
  );

  int n_chk = 0;
  int n_fail = 0;

  function automatic void bad(input string tag,
                              input logic [31:0] obs,
                              input logic [31:0] exp);
    n_fail++;
    $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endfunction

  logic [7:0]  q[$];
  int unsigned wr_n, rd_n;
  logic [7:0]  ram [ELS];
  logic [7:0]  d0, d1;

  logic          s_w_v, s_r_v, s_ready, s_deq_v, s_yumi, s_ordy;
  logic [AW-1:0] s_w_addr, s_r_addr;
  logic [P-1:0]  s_pipe;
  logic [7:0]    s_data;

  task automatic model_clear();
    q.delete();
    wr_n = 0;
    rd_n = 0;
  endtask

  task automatic cyc(input logic e, input logic want_y, input logic [7:0] din);
    enq_v = e;
    yumi  = want_y & deq_v;
    #1;
    s_w_v = w_v;  s_w_addr = w_addr;
    s_r_v = r_v;  s_r_addr = r_addr;
    s_ready = enq_ready; s_deq_v = deq_v; s_pipe = pipe;
    s_yumi = yumi; s_ordy = out_rdy; s_data = d1;
    n_chk++;
    if (cnt !== CW'(q.size())) bad("count", cnt, q.size());
    n_chk++;
    if (w_v !== (e & enq_ready)) bad("w_v", w_v, e & enq_ready);
    n_chk++;
    if (out_rdy !== yumi) bad("out_rdy", out_rdy, yumi);
    if (q.size() == ELS + P) begin
      n_chk++;
      if (enq_ready !== 1'b0) bad("full_ready", enq_ready, 0);
    end
    if (deq_v) begin
      n_chk++;
      if (q.size() == 0) bad("deq_v_nonempty", 0, 1);
    end
    if (w_v) begin
      n_chk++;
      if (w_addr !== AW'(wr_n % ELS)) bad("w_addr", w_addr, wr_n % ELS);
    end
    if (r_v) begin
      n_chk++;
      if (r_addr !== AW'(rd_n % ELS)) bad("r_addr", r_addr, rd_n % ELS);
      n_chk++;
      if (wr_n <= rd_n) bad("r_avail", rd_n, wr_n);
    end
    if (yumi) begin
      n_chk++;
      if (d1 !== q[0]) bad("deq_data", d1, q[0]);
    end
    @(posedge clk);
    if (s_ordy | ~s_pipe[1]) d1 = d0;
    if (s_r_v) begin
      d0 = ram[s_r_addr];
      rd_n++;
    end
    if (s_w_v) begin
      ram[s_w_addr] = din;
      q.push_back(din);
      wr_n++;
    end
    if (s_yumi) void'(q.pop_front());
    @(negedge clk);
  endtask

  task automatic do_reset();
    enq_v = 1'b0;
    yumi  = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int acc;
    int sent;
    model_clear();
    #1 rst_n = 1'b0;
    #2;
    n_chk++;
    if (enq_ready !== 1'b1) bad("rst_ready", enq_ready, 1);
    n_chk++;
    if (deq_v !== 1'b0) bad("rst_deq_v", deq_v, 0);
    n_chk++;
    if (pipe !== 2'b00) bad("rst_pipe", pipe, 0);
    n_chk++;
    if (cnt !== 3'd0) bad("rst_count", cnt, 0);
    n_chk++;
    if (r_v !== 1'b0) bad("rst_r_v", r_v, 0);
    n_chk++;
    if (w_v !== 1'b0) bad("rst_w_v", w_v, 0);
    @(negedge clk);
    rst_n = 1'b1;

    cyc(1'b1, 1'b0, 8'hA5);
    n_chk++;
    if (s_w_v !== 1'b1) bad("t2_w_v", s_w_v, 1);
    n_chk++;
    if (s_w_addr !== 2'd0) bad("t2_w_addr", s_w_addr, 0);
    cyc(1'b0, 1'b0, 8'h00);
    n_chk++;
    if (s_r_v !== 1'b1) bad("t2_r_v", s_r_v, 1);
    n_chk++;
    if (s_r_addr !== 2'd0) bad("t2_r_addr", s_r_addr, 0);
    cyc(1'b0, 1'b0, 8'h00);
    n_chk++;
    if (s_pipe !== 2'b01) bad("t2_pipe", s_pipe, 1);
    n_chk++;
    if (s_deq_v !== 1'b0) bad("t2_deq_v_early", s_deq_v, 0);
    cyc(1'b0, 1'b1, 8'h00);
    n_chk++;
    if (s_deq_v !== 1'b1) bad("t2_deq_v", s_deq_v, 1);
    n_chk++;
    if (s_data !== 8'hA5) bad("t2_data", s_data, 8'hA5);
    cyc(1'b0, 1'b0, 8'h00);
    n_chk++;
    if (s_deq_v !== 1'b0) bad("t2_empty", s_deq_v, 0);

    do_reset();
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b0, 8'(i));
      acc += int'(s_w_v);
    end
    n_chk++;
    if (acc != 6) bad("t3_accepted", acc, 6);
    cyc(1'b0, 1'b0, 8'h00);
    n_chk++;
    if (s_ready !== 1'b0) bad("t3_ready", s_ready, 0);
    n_chk++;
    if (cnt !== 3'd6) bad("t3_count", cnt, 6);

    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b0, 8'h00);
      n_chk++;
      if (s_deq_v !== 1'b1) bad("t4_stall_v", s_deq_v, 1);
      n_chk++;
      if (s_data !== 8'h00) bad("t4_stall_data", s_data, 0);
    end
    cyc(1'b0, 1'b1, 8'h00);
    n_chk++;
    if (s_r_v !== 1'b1) bad("t4_first_rd", s_r_v, 1);
    n_chk++;
    if (s_ready !== 1'b0) bad("t4_ready_lo", s_ready, 0);
    n_chk++;
    if (s_yumi !== 1'b1) bad("t4_stream0", s_yumi, 1);
    cyc(1'b0, 1'b1, 8'h00);
    n_chk++;
    if (s_ready !== 1'b1) bad("t4_ready_hi", s_ready, 1);
    n_chk++;
    if (s_yumi !== 1'b1) bad("t4_stream1", s_yumi, 1);
    for (int i = 2; i < 6; i++) begin
      cyc(1'b0, 1'b1, 8'h00);
      n_chk++;
      if (s_yumi !== 1'b1) bad("t4_stream", s_yumi, 1);
    end
    cyc(1'b0, 1'b0, 8'h00);
    n_chk++;
    if (s_deq_v !== 1'b0) bad("t4_drained", s_deq_v, 0);

    do_reset();
    sent = 0;
    for (int c = 0; c < 200 && (sent < 10 || q.size() > 0); c++) begin
      cyc(sent < 10, 1'($urandom_range(0, 1)), 8'(sent + 16));
      sent += int'(s_w_v);
    end
    n_chk++;
    if (sent != 10) bad("t5_sent", sent, 10);
    n_chk++;
    if (q.size() != 0) bad("t5_drained", q.size(), 0);

    for (int c = 0; c < 400; c++)
      cyc(1'($urandom), 1'($urandom), 8'($urandom));
    for (int c = 0; c < 50 && q.size() > 0; c++)
      cyc(1'b0, 1'b1, 8'h00);
    n_chk++;
    if (q.size() != 0) bad("rand_drained", q.size(), 0);

    do_reset();
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 8'(i));
    cyc(1'b0, 1'b0, 8'h00);
    n_chk++;
    if (cnt !== 3'd3) bad("t6_count3", cnt, 3);
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if (enq_ready !== 1'b1) bad("t6_ready", enq_ready, 1);
    n_chk++;
    if (deq_v !== 1'b0) bad("t6_deq_v", deq_v, 0);
    n_chk++;
    if (cnt !== 3'd0) bad("t6_count", cnt, 0);
    n_chk++;
    if (pipe !== 2'b00) bad("t6_pipe", pipe, 0);
    n_chk++;
    if (r_v !== 1'b0) bad("t6_r_v", r_v, 0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;

`ifdef MEM_1R1W_FIFO_CTRL_CLEAR_EN
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 8'(i));
    cyc(1'b0, 1'b0, 8'h00);
    n_chk++;
    if (cnt !== 3'd3) bad("clr_count3", cnt, 3);
    clear = 1'b1;
    cyc(1'b1, 1'b0, 8'h77);
    n_chk++;
    if (s_ready !== 1'b0) bad("clr_ready", s_ready, 0);
    n_chk++;
    if (s_r_v !== 1'b0) bad("clr_r_v", s_r_v, 0);
    clear = 1'b0;
    model_clear();
    cyc(1'b1, 1'b0, 8'h55);
    n_chk++;
    if (s_w_addr !== 2'd0) bad("clr_w_addr", s_w_addr, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
